// File: rtl/piezo_pkg.sv
// piezo_pkg: alert classes, sequencer states and per-class beep pattern constants
// shared by the piezo alert scheduler and its tone generator.
package piezo_pkg;
    typedef enum logic [1:0] {CLS_NONE, CLS_MOVE, CLS_BATT, CLS_OVR} alert_cls_t;
    typedef enum logic [1:0] {IDLE, BEEP, GAP, REST} piezo_state_t;

    localparam int OVR_ON = 100, OVR_GAP = 100, OVR_REST = 200, OVR_N = 3;
    localparam int BATT_ON = 200, BATT_GAP = 200, BATT_REST = 1000, BATT_N = 2;
    localparam int MOVE_ON = 50, MOVE_GAP = 0, MOVE_REST = 2000, MOVE_N = 1;
    localparam int MAX_TICKS = 2000;

    function automatic int pat_ticks(input alert_cls_t cls, input piezo_state_t st);
        int on_t, gap_t, rest_t;
        on_t = cls == CLS_OVR ? OVR_ON : cls == CLS_BATT ? BATT_ON : MOVE_ON;
        gap_t = cls == CLS_OVR ? OVR_GAP : cls == CLS_BATT ? BATT_GAP : MOVE_GAP;
        rest_t = cls == CLS_OVR ? OVR_REST : cls == CLS_BATT ? BATT_REST : MOVE_REST;
        return st == BEEP ? on_t : st == GAP ? gap_t : rest_t;
    endfunction

    function automatic int beep_n(input alert_cls_t cls);
        return cls == CLS_OVR ? OVR_N : cls == CLS_BATT ? BATT_N : MOVE_N;
    endfunction
endpackage

// File: rtl/piezo_tone_gen.sv
// piezo_tone_gen: square-wave tone for the selected alert class; restarts high on
// enable rise or class change and holds everything cleared while disabled.
module piezo_tone_gen
    import piezo_pkg::*;
#(
    parameter int OVR_HALF = 12500,
    parameter int BATT_HALF = 25000,
    parameter int MOVE_HALF = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] sel,
    output logic       audio_o
);
    localparam int MAXH = OVR_HALF > BATT_HALF ? (OVR_HALF > MOVE_HALF ? OVR_HALF : MOVE_HALF)
                                               : (BATT_HALF > MOVE_HALF ? BATT_HALF : MOVE_HALF);
    localparam int W = $clog2(MAXH) < 1 ? 1 : $clog2(MAXH);

    logic [W-1:0] cnt, lim;
    logic [1:0] sel_q;
    logic on;

    assign lim = sel == CLS_OVR ? W'(OVR_HALF - 1) : sel == CLS_BATT ? W'(BATT_HALF - 1) : W'(MOVE_HALF - 1);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt <= '0;
            sel_q <= '0;
            on <= 1'b0;
            audio_o <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            sel_q <= '0;
            on <= 1'b0;
            audio_o <= 1'b0;
        end else if (!on || sel != sel_q) begin
            cnt <= '0;
            sel_q <= sel;
            on <= 1'b1;
            audio_o <= 1'b1;
        end else if (cnt == lim) begin
            cnt <= '0;
            audio_o <= !audio_o;
        end else begin
            cnt <= cnt + W'(1);
        end
endmodule

// File: rtl/piezo_alert_sched.sv
// piezo_alert_sched: arbitrates over-speed/battery-low/moving alerts and sequences their
// beep patterns onto the differential piezo pins. PIEZO_MUTE_EN adds mute_req.
module piezo_alert_sched
    import piezo_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int OVR_HALF = 12500,
    parameter int BATT_HALF = 25000,
    parameter int MOVE_HALF = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ovr_spd,
    input  logic       batt_low,
    input  logic       moving,
`ifdef PIEZO_MUTE_EN
    input  logic       mute_req,
`endif
    output logic       audio_o,
    output logic       audio_o_n,
    output logic [1:0] alert_cls,
    output logic       busy
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(MAX_TICKS);

    piezo_state_t state, nxt_state;
    alert_cls_t cls, nxt_cls, win;
    logic [1:0] bc, nxt_bc;
    logic [PW-1:0] pre;
    logic [DW-1:0] dur;
    logic load, tick, expire, any_req, elig_batt, elig_move, mute_hit;

`ifdef PIEZO_MUTE_EN
    logic mute_batt, mute_move;
    assign mute_hit = mute_req && (cls == CLS_BATT || cls == CLS_MOVE);
    assign elig_batt = batt_low && !mute_batt;
    assign elig_move = moving && !mute_move;
    // A mute flag survives only while its request stays asserted.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mute_batt <= 1'b0;
            mute_move <= 1'b0;
        end else begin
            mute_batt <= batt_low && (mute_batt || (mute_hit && cls == CLS_BATT));
            mute_move <= moving && (mute_move || (mute_hit && cls == CLS_MOVE));
        end
`else
    assign mute_hit = 1'b0;
    assign elig_batt = batt_low;
    assign elig_move = moving;
`endif

    assign win = ovr_spd ? CLS_OVR : elig_batt ? CLS_BATT : elig_move ? CLS_MOVE : CLS_NONE;
    assign any_req = ovr_spd || batt_low || moving;
    assign tick = pre == PW'(TICK_DIV - 1);
    assign expire = tick && dur == DW'(pat_ticks(cls, state) - 1);

    always_comb begin
        nxt_state = state;
        nxt_cls = cls;
        nxt_bc = bc;
        load = 1'b0;
        if (mute_hit) begin
            nxt_state = IDLE;
            nxt_cls = CLS_NONE;
            nxt_bc = 2'd0;
            load = 1'b1;
        end else if (state == IDLE) begin
            load = 1'b1;
            nxt_state = win != CLS_NONE ? BEEP : IDLE;
            nxt_cls = win;
            nxt_bc = win != CLS_NONE ? 2'd1 : 2'd0;
        end else if (win > cls) begin
            nxt_state = BEEP;
            nxt_cls = win;
            nxt_bc = 2'd1;
            load = 1'b1;
        end else if (state != BEEP && !any_req) begin
            nxt_state = IDLE;
            nxt_cls = CLS_NONE;
            nxt_bc = 2'd0;
            load = 1'b1;
        end else if (expire && state == BEEP) begin
            nxt_state = int'(bc) < beep_n(cls) ? GAP : REST;
            load = 1'b1;
        end else if (expire) begin
            nxt_state = win != CLS_NONE ? BEEP : IDLE;
            nxt_cls = win;
            nxt_bc = win == CLS_NONE ? 2'd0 : (state == GAP && win == cls) ? bc + 2'd1 : 2'd1;
            load = 1'b1;
        end
    end

    // Prescaler and duration restart on every state entry so each state lasts whole ticks.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            cls <= CLS_NONE;
            bc <= 2'd0;
            pre <= '0;
            dur <= '0;
        end else begin
            state <= nxt_state;
            cls <= nxt_cls;
            bc <= nxt_bc;
            pre <= (load || tick) ? '0 : pre + PW'(1);
            dur <= load ? '0 : tick ? dur + DW'(1) : dur;
        end

    piezo_tone_gen #(
        .OVR_HALF(OVR_HALF),
        .BATT_HALF(BATT_HALF),
        .MOVE_HALF(MOVE_HALF)
    ) u_tone (
        .clk(clk),
        .rst_n(rst_n),
        .en(nxt_state == BEEP),
        .sel(nxt_cls),
        .audio_o(audio_o)
    );

    assign audio_o_n = state == BEEP && !audio_o;
    assign alert_cls = cls;
    assign busy = state != IDLE;
endmodule

// File: tb/tb_piezo_alert_sched.sv
// tb_piezo_alert_sched: directed checks of pattern timing, preemption, tone phase and reset
// with TICK_DIV=10, OVR_HALF=5, BATT_HALF=10, MOVE_HALF=20.
module tb_piezo_alert_sched;
    logic clk = 1'b0, rst_n = 1'b0, ovr_spd = 1'b0, batt_low = 1'b0, moving = 1'b0;
`ifdef PIEZO_MUTE_EN
    logic mute_req = 1'b0;
`endif
    logic audio_o, audio_o_n, busy;
    logic [1:0] alert_cls;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    piezo_alert_sched #(
        .TICK_DIV(10),
        .OVR_HALF(5),
        .BATT_HALF(10),
        .MOVE_HALF(20)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ovr_spd(ovr_spd),
        .batt_low(batt_low),
        .moving(moving),
`ifdef PIEZO_MUTE_EN
        .mute_req(mute_req),
`endif
        .audio_o(audio_o),
        .audio_o_n(audio_o_n),
        .alert_cls(alert_cls),
        .busy(busy)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic b, input logic [1:0] c, input logic a, input logic an);
        logic [4:0] obs, exp;
        obs = {busy, alert_cls, audio_o, audio_o_n};
        exp = {b, c, a, an};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s busy/cls/audio/audio_n observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        step(2);
        chk("reset", 0, 0, 0, 0);
        rst_n = 1'b1;
        step(1);
        chk("idle", 0, 0, 0, 0);
        moving = 1'b1;
        step(1);
        chk("move_beep_entry", 1, 1, 1, 0);
        step(19);
        chk("move_high_end", 1, 1, 1, 0);
        step(1);
        chk("move_first_toggle", 1, 1, 0, 1);
        step(479);
        chk("move_beep_last", 1, 1, 1, 0);
        step(1);
        chk("move_rest_entry", 1, 1, 0, 0);
        step(19999);
        chk("move_rest_last", 1, 1, 0, 0);
        step(1);
        chk("move_repeat", 1, 1, 1, 0);
        step(500);
        chk("move_rest2", 1, 1, 0, 0);
        ovr_spd = 1'b1;
        step(1);
        chk("ovr_preempt", 1, 3, 1, 0);
        step(4);
        chk("ovr_high_end", 1, 3, 1, 0);
        step(1);
        chk("ovr_toggle", 1, 3, 0, 1);
        step(994);
        chk("ovr_beep1_last", 1, 3, 0, 1);
        step(1);
        chk("ovr_gap1", 1, 3, 0, 0);
        step(1000);
        chk("ovr_beep2", 1, 3, 1, 0);
        step(2999);
        chk("ovr_beep3_last", 1, 3, 0, 1);
        step(1);
        chk("ovr_rest", 1, 3, 0, 0);
        step(1999);
        chk("ovr_rest_last", 1, 3, 0, 0);
        step(1);
        chk("ovr_repeat", 1, 3, 1, 0);
        ovr_spd = 1'b0;
        moving = 1'b0;
        batt_low = 1'b1;
        step(999);
        chk("ovr_not_shortened", 1, 3, 0, 1);
        step(1);
        chk("ovr_gap_batt_wait", 1, 3, 0, 0);
        step(1000);
        chk("batt_beep", 1, 2, 1, 0);
        step(10);
        chk("batt_toggle", 1, 2, 0, 1);
        step(490);
        batt_low = 1'b0;
        step(1499);
        chk("batt_full_beep", 1, 2, 0, 1);
        step(1);
        chk("batt_exit", 1, 2, 0, 0);
        step(1);
        chk("batt_idle", 0, 0, 0, 0);
        batt_low = 1'b1;
        step(1);
        chk("batt_restart", 1, 2, 1, 0);
        step(3);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 0, 0, 0, 0);
        step(1);
        chk("reset_held", 0, 0, 0, 0);
        rst_n = 1'b1;
        step(1);
        chk("reset_release", 1, 2, 1, 0);
`ifdef PIEZO_MUTE_EN
        moving = 1'b1;
        mute_req = 1'b1;
        step(1);
        mute_req = 1'b0;
        chk("mute_idle", 0, 0, 0, 0);
        step(1);
        chk("mute_move_start", 1, 1, 1, 0);
        ovr_spd = 1'b1;
        step(1);
        chk("mute_ovr_preempt", 1, 3, 1, 0);
        mute_req = 1'b1;
        step(1);
        mute_req = 1'b0;
        chk("mute_ovr_ignored", 1, 3, 1, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
